// File: rtl/issue_pkg.sv
// Shared types for the in-order issue queue: the decoded entry layout and
// the structural pairing rule applied to the two oldest entries.
package issue_pkg;

  localparam int PAYLOAD_W = 64;

  typedef struct packed {
    logic [31:0]          pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 reg_write;
    logic                 is_load;
    logic                 is_store;
    logic                 is_branch;
    logic [PAYLOAD_W-1:0] ctrl;
  } issue_entry_t;

  // A branch in slot0 ends the group; only one memory port exists.
  function automatic logic can_pair(input issue_entry_t head0, input issue_entry_t head1);
    logic mem0;
    logic mem1;
    mem0 = head0.is_load | head0.is_store;
    mem1 = head1.is_load | head1.is_store;
    return !head0.is_branch && !(mem0 && mem1);
  endfunction

endpackage

// File: rtl/issue_queue.sv
// Dual-enqueue, dual-issue in-order ring buffer between decode and the
// scoreboard; issues up to the two oldest entries per cycle.
module issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     ex_stall,
  input  logic                     in_valid0,
  input  logic                     in_valid1,
  input  issue_entry_t             in_entry0,
  input  issue_entry_t             in_entry1,
  output logic                     in_ready,
  output logic [4:0]               rs1_0,
  output logic [4:0]               rs2_0,
  output logic [4:0]               rs1_1,
  output logic [4:0]               rs2_1,
  output logic                     use_rs1_0,
  output logic                     use_rs2_0,
  output logic                     use_rs1_1,
  output logic                     use_rs2_1,
  output logic [4:0]               rd0_issue,
  output logic [4:0]               rd1_issue,
  output logic                     reg_write0_issue,
  output logic                     reg_write1_issue,
  output logic                     is_load0_issue,
  output logic                     is_load1_issue,
  input  logic                     raw_hazard0,
  input  logic                     raw_hazard1,
  input  logic                     waw_hazard0,
  input  logic                     waw_hazard1,
  input  logic                     load_use0,
  input  logic                     load_use1,
  output logic                     issue0,
  output logic                     issue1,
  output issue_entry_t             issue_entry0,
  output issue_entry_t             issue_entry1,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              perf_dual,
  output logic [31:0]              perf_single,
  output logic [31:0]              perf_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] L_DEPTH     = (PW+1)'(DEPTH);
  localparam logic [PW:0] L_READY_MAX = (PW+1)'(DEPTH - 2);

  issue_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_occ;
  logic [31:0]   r_perf_dual;
  logic [31:0]   r_perf_single;
  logic [31:0]   r_perf_stall;

  issue_entry_t  w_head0;
  issue_entry_t  w_head1;
  logic          w_head0_valid;
  logic          w_head1_valid;
  logic          w_enq0;
  logic          w_enq1;
  logic [PW:0]   w_nenq;
  logic [PW:0]   w_ndeq;

  assign w_head0       = r_mem[r_rd_ptr];
  assign w_head1       = r_mem[r_rd_ptr + PW'(1)];
  assign w_head0_valid = (r_occ != '0);
  assign w_head1_valid = (r_occ > (PW+1)'(1));

  // Readiness reserves room for a full pair and ignores same-cycle dequeue.
  assign in_ready = (r_occ <= L_READY_MAX);
  assign w_enq0   = in_ready & in_valid0 & ~flush;
  assign w_enq1   = w_enq0 & in_valid1;
  assign w_nenq   = (PW+1)'(w_enq0) + (PW+1)'(w_enq1);

  // issue0 must stay independent of the slot1 hazards to keep the scoreboard loop-free.
  assign issue0 = w_head0_valid & ~flush & ~ex_stall & ~raw_hazard0 & ~waw_hazard0;
  assign issue1 = issue0 & w_head1_valid & ~raw_hazard1 & ~waw_hazard1
                & can_pair(w_head0, w_head1);
  assign w_ndeq = (PW+1)'(issue0) + (PW+1)'(issue1);

  assign issue_entry0 = w_head0;
  assign issue_entry1 = w_head1;

  assign rs1_0            = w_head0_valid ? w_head0.rs1       : 5'd0;
  assign rs2_0            = w_head0_valid ? w_head0.rs2       : 5'd0;
  assign use_rs1_0        = w_head0_valid & w_head0.use_rs1;
  assign use_rs2_0        = w_head0_valid & w_head0.use_rs2;
  assign rd0_issue        = w_head0_valid ? w_head0.rd        : 5'd0;
  assign reg_write0_issue = w_head0_valid & w_head0.reg_write;
  assign is_load0_issue   = w_head0_valid & w_head0.is_load;
  assign rs1_1            = w_head1_valid ? w_head1.rs1       : 5'd0;
  assign rs2_1            = w_head1_valid ? w_head1.rs2       : 5'd0;
  assign use_rs1_1        = w_head1_valid & w_head1.use_rs1;
  assign use_rs2_1        = w_head1_valid & w_head1.use_rs2;
  assign rd1_issue        = w_head1_valid ? w_head1.rd        : 5'd0;
  assign reg_write1_issue = w_head1_valid & w_head1.reg_write;
  assign is_load1_issue   = w_head1_valid & w_head1.is_load;

  assign occupancy   = r_occ;
  assign perf_dual   = r_perf_dual;
  assign perf_single = r_perf_single;
  assign perf_stall  = r_perf_stall;

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (w_enq0) r_mem[r_wr_ptr] <= in_entry0;
    if (w_enq1) r_mem[r_wr_ptr + PW'(1)] <= in_entry1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_occ         <= '0;
      r_perf_dual   <= '0;
      r_perf_single <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_occ    <= '0;
      end else begin
        r_rd_ptr <= r_rd_ptr + PW'(w_ndeq);
        r_wr_ptr <= r_wr_ptr + PW'(w_nenq);
        r_occ    <= r_occ + w_nenq - w_ndeq;
      end
      r_perf_dual   <= r_perf_dual + 32'(issue1);
      r_perf_single <= r_perf_single + 32'(issue0 & ~issue1);
      r_perf_stall  <= r_perf_stall + 32'(w_head0_valid & ~issue0 & ~flush);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_occ <= L_DEPTH);
      assert (!issue1 || issue0);
      assert (w_nenq == '0 || in_ready);
      assert (!load_use0 || raw_hazard0);
      assert (!load_use1 || raw_hazard1);
    end
  end
`endif

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Decoupling buffer between decode and the scoreboard/issue point of the dual-issue RV32I core.
- Accepts up to two decoded instructions per cycle and holds them in a program-order ring.
- Presents the two oldest entries to reg_status_table as slot0/slot1 and consumes its hazard flags.
- Generates issue0/issue1 in order, applies pairing rules, and hands issued entries to execute.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all queued entries (redirect)
- ex_stall  in  1  execute cannot accept this cycle
- in_valid0, in_valid1  in  1 each  decode enqueue requests; slot0 is older
- in_entry0, in_entry1  in  issue_entry_t each  decoded instructions
- in_ready  out  1  queue can take two entries this cycle
- rs1_0, rs2_0, rs1_1, rs2_1  out  5 each  head source registers to scoreboard
- use_rs1_0, use_rs2_0, use_rs1_1, use_rs2_1  out  1 each  source-used flags
- rd0_issue, rd1_issue  out  5 each  head destination registers
- reg_write0_issue, reg_write1_issue, is_load0_issue, is_load1_issue  out  1 each  head write/load flags
- raw_hazard0, raw_hazard1, waw_hazard0, waw_hazard1, load_use0, load_use1  in  1 each  scoreboard hazards
- issue0, issue1  out  1 each  slot issues this cycle
- issue_entry0, issue_entry1  out  issue_entry_t each  issued payload to execute
- occupancy  out  $clog2(DEPTH)+1  valid entry count
- perf_dual, perf_single, perf_stall  out  32 each  performance counters

Behaviour:
- Reset (synchronous): rd_ptr=wr_ptr=0, occupancy=0, perf counters=0. Consequently issue0=issue1=0 and in_ready=1.
- Scoreboard outputs: head0 = entry[rd_ptr], head1 = entry[rd_ptr+1]. Scoreboard-facing fields are driven from these heads and forced to 0 when the head is invalid (head0 valid iff occupancy>=1, head1 iff occupancy>=2).
- in_ready = (occupancy <= DEPTH-2). It uses current occupancy only; same-cycle dequeue gives no credit.
- Enqueue: only when in_ready.
  - in_valid0 writes at wr_ptr; in_valid1 writes at wr_ptr+1.
  - in_valid1 without in_valid0 is ignored (decode compacts).
  - No input-to-issue bypass: an entry is issuable no earlier than the cycle after enqueue.
- Issue, combinational:
  - issue0 = head0 valid & !flush & !ex_stall & !raw_hazard0 & !waw_hazard0.
  - issue1 = issue0 & head1 valid & !raw_hazard1 & !waw_hazard1 & !head0.is_branch & !(mem(head0) & mem(head1)), where mem = is_load|is_store.
  - load_use* are a subset of raw_hazard* and are not a separate gate.
  - issue0 must not depend on any *_1 hazard input; this keeps the scoreboard path (hazard1 depends on issue0) loop-free.
- Dequeue: rd_ptr advances by issue0+issue1. Pointers wrap modulo DEPTH. occupancy_next = occupancy + nenq - ndeq.
- Flush: has priority over enqueue, issue and dequeue. Next cycle rd_ptr=wr_ptr=0 and occupancy=0. Perf counters are not cleared.
- issue_entry0/1 carry head0/head1 contents and are meaningful only when the matching issue bit is set.
- Perf counters, 32-bit, wrap:
  - perf_dual += issue1.
  - perf_single += issue0 & !issue1.
  - perf_stall += head0 valid & !issue0 & !flush.
- Assertions:
  - occupancy never exceeds DEPTH.
  - issue1 implies issue0.
  - No enqueue while !in_ready.

Decomposition:
- issue_pkg contains:
  - issue_entry_t (pc[31:0], rs1, rs2, rd [4:0], use_rs1, use_rs2, reg_write, is_load, is_store, is_branch, ctrl[PAYLOAD_W-1:0]).
  - PAYLOAD_W = 64.
  - function can_pair(head0, head1) implementing the structural pairing rules.
- No sub-module: ring storage and issue logic stay in one module.

Test Plan:
- Reset, enqueue addi x1 / addi x2 (independent), no hazards -> next cycle issue0=issue1=1, perf_dual=1, occupancy 2->0.
- add x3,x1,x2 then add x4,x3,x0 with scoreboard raising raw_hazard1 -> issue0=1, issue1=0, perf_single=1; next cycle the second instruction is head0 and rs1_0=3.
- lw x5 issued earlier, head0 add x6,x5,x0 with load_use0=raw_hazard0=1 for 2 cycles -> issue0=0 for both cycles, perf_stall+=2, issue0=1 on the third cycle.
- ex_stall=1, enqueue 4 pairs into DEPTH=8 -> in_ready=0 once occupancy=8 (de-asserts after occupancy 6->8); a fifth pair is ignored and occupancy stays 8.
- occupancy=5 with flush=1 plus simultaneous in_valid0/1 -> next cycle occupancy=0, issue0=0, no entry written.
- Stream 20 instructions, PCs 0x0..0x4C, random ex_stall plus pairs of lw/sw -> issued PCs strictly sequential across pointer wrap; never two memory ops issued together.
